// File: rtl/mure_retire_serializer.sv
// Buffers multi-lane retirement packets (plus an optional trap) in a FIFO and
// serialises them into one trace record per cycle over a valid/ready handshake.
module mure_retire_serializer #(
  parameter int unsigned NrRetiredInstr = 2,
  parameter int unsigned FifoDepth      = 8,
  parameter int unsigned XLEN           = 64,
  parameter int unsigned INST_LEN       = 32,
  parameter int unsigned CAUSE_LEN      = 64,
  parameter int unsigned PRIV_LEN       = 2,
  parameter int unsigned CntWidth       = 16
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NrRetiredInstr-1:0]          valids_i,
  input  logic [NrRetiredInstr*INST_LEN-1:0] uops_i,
  input  logic [NrRetiredInstr*XLEN-1:0]     pcs_i,
  input  logic [NrRetiredInstr-1:0]          compressed_i,
  input  logic                               exception_i,
  input  logic                               interrupt_i,
  input  logic                               eret_i,
  input  logic [CAUSE_LEN-1:0]               cause_i,
  input  logic [XLEN-1:0]                    tval_i,
  input  logic [XLEN-1:0]                    epc_i,
  input  logic [PRIV_LEN-1:0]                priv_lvl_i,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic                               iretired_o,
  output logic                               exception_o,
  output logic                               interrupt_o,
  output logic                               eret_o,
  output logic [INST_LEN-1:0]                inst_data_o,
  output logic                               compressed_o,
  output logic [XLEN-1:0]                    pc_o,
  output logic [CAUSE_LEN-1:0]               cause_o,
  output logic [XLEN-1:0]                    tval_o,
  output logic [PRIV_LEN-1:0]                priv_lvl_o,
  output logic                               full_o,
  output logic                               overflow_o,
  output logic [CntWidth-1:0]                drop_cnt_o
);

  localparam int unsigned AW = $clog2(FifoDepth);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned LW = $clog2(NrRetiredInstr) + 1;

  typedef struct packed {
    logic [NrRetiredInstr-1:0]          valids;
    logic [NrRetiredInstr*INST_LEN-1:0] uops;
    logic [NrRetiredInstr*XLEN-1:0]     pcs;
    logic [NrRetiredInstr-1:0]          comp;
    logic                               exc;
    logic                               irq;
    logic                               eret;
    logic [CAUSE_LEN-1:0]               cause;
    logic [XLEN-1:0]                    tval;
    logic [XLEN-1:0]                    epc;
    logic [PRIV_LEN-1:0]                priv;
  } pkt_t;

  typedef enum logic [1:0] {S_IDLE, S_LANES, S_TRAP} state_e;

  pkt_t          r_mem [FifoDepth];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic [LW-1:0] r_lane, w_lane_n;
  state_e        r_state, w_state, w_state_n;
  logic          r_overflow;
  logic [CntWidth-1:0] r_drop_cnt;

  pkt_t          w_in, w_head;
  logic          w_push, w_push_ok, w_pop, w_full, w_empty, w_has_trap, w_fire;
  logic          w_found, w_more, w_last, w_valid;
  logic [LW-1:0] w_sel;

  assign w_push    = (|valids_i) | exception_i | interrupt_i;
  assign w_full    = (r_count == CW'(FifoDepth));
  assign w_empty   = (r_count == '0);
  assign w_push_ok = w_push & ~w_full;
  assign w_head    = r_mem[r_rptr];
  assign w_has_trap = w_head.exc | w_head.irq;

  // Interrupt takes precedence over exception when both are raised.
  always_comb begin
    w_in        = '0;
    w_in.valids = valids_i;
    w_in.uops   = uops_i;
    w_in.pcs    = pcs_i;
    w_in.comp   = compressed_i;
    w_in.exc    = exception_i & ~interrupt_i;
    w_in.irq    = interrupt_i;
    w_in.eret   = eret_i;
    w_in.cause  = cause_i;
    w_in.tval   = tval_i;
    w_in.epc    = epc_i;
    w_in.priv   = priv_lvl_i;
  end

  always_ff @(posedge clk_i) begin
    if (w_push_ok) r_mem[r_wptr] <= w_in;
  end

  // Lowest valid lane at or above the lane index, and whether any remain above it.
  always_comb begin
    w_sel   = '0;
    w_found = 1'b0;
    w_more  = 1'b0;
    for (int unsigned i = 0; i < NrRetiredInstr; i++) begin
      if (w_head.valids[i] && (i >= 32'(r_lane))) begin
        if (!w_found) begin
          w_found = 1'b1;
          w_sel   = LW'(i);
        end else begin
          w_more = 1'b1;
        end
      end
    end
    w_last = ~w_more;
  end

  // IDLE resolves to the head's first state in the same cycle, so there is no
  // bubble after a pop or after a push into an empty FIFO.
  always_comb begin
    w_state = r_state;
    if (r_state == S_IDLE && !w_empty)
      w_state = (|w_head.valids) ? S_LANES : S_TRAP;
  end

  always_comb begin
    w_valid      = 1'b0;
    iretired_o   = 1'b0;
    exception_o  = 1'b0;
    interrupt_o  = 1'b0;
    eret_o       = 1'b0;
    inst_data_o  = '0;
    compressed_o = 1'b0;
    pc_o         = '0;
    cause_o      = '0;
    tval_o       = '0;
    priv_lvl_o   = '0;
    case (w_state)
      S_LANES: begin
        w_valid      = 1'b1;
        iretired_o   = 1'b1;
        eret_o       = w_head.eret & w_last;
        inst_data_o  = w_head.uops[w_sel*INST_LEN +: INST_LEN];
        compressed_o = w_head.comp[w_sel];
        pc_o         = w_head.pcs[w_sel*XLEN +: XLEN];
        priv_lvl_o   = w_head.priv;
      end
      S_TRAP: begin
        w_valid     = 1'b1;
        exception_o = w_head.exc;
        interrupt_o = w_head.irq;
        pc_o        = w_head.epc;
        cause_o     = w_head.cause;
        tval_o      = w_head.tval;
        priv_lvl_o  = w_head.priv;
      end
      default: ;
    endcase
  end

  assign out_valid_o = w_valid;
  assign w_fire      = w_valid & out_ready_i;

  always_comb begin
    w_state_n = w_state;
    w_lane_n  = r_lane;
    w_pop     = 1'b0;
    if (w_fire) begin
      case (w_state)
        S_LANES: begin
          if (!w_last) begin
            w_lane_n = w_sel + 1'b1;
          end else if (w_has_trap) begin
            w_state_n = S_TRAP;
            w_lane_n  = w_sel + 1'b1;
          end else begin
            w_pop     = 1'b1;
            w_state_n = S_IDLE;
            w_lane_n  = '0;
          end
        end
        S_TRAP: begin
          w_pop     = 1'b1;
          w_state_n = S_IDLE;
          w_lane_n  = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_lane     <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_state    <= w_state_n;
      r_lane     <= w_lane_n;
      r_overflow <= w_push & w_full;
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop)     r_rptr <= r_rptr + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_push && w_full && (r_drop_cnt != '1))
        r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  assign full_o     = w_full;
  assign overflow_o = r_overflow;
  assign drop_cnt_o = r_drop_cnt;

endmodule
